mux4a1_collector: RTL and testbench

MUX4A1_COLLECTOR -- requirements
Module: mux4a1_collector

---
 rtl/mux4a1_collector.sv | 137 +++++++++++++
 tb/tb_mux4a1_collector.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4a1_collector.sv
// mxv_pkg / mux4a1_collector
//
// Purpose: 4-to-1 collector. Four valid/ready input channels are arbitrated
// into a single registered output stage. Selector carries the index of the
// channel that produced Data_out, so a downstream Selector-steered demux can
// route the beat back out.
//
// Parameters:
//   RR_EN       1 = round-robin arbitration, 0 = fixed priority (ch0 highest)
//
// Ports:
//   clk                      rising-edge clock
//   rst_n                    asynchronous active-low reset
//   Data_in_0..3   (in)      channel payloads
//   Valid_in_0..3  (in)      channel n offers a beat
//   Ready_in_0..3  (out)     channel n beat accepted this cycle (combinational)
//   Data_out       (out)     registered collected payload
//   Selector       (out)     source channel of Data_out, registered with it
//   Valid_out      (out)     Data_out/Selector hold a beat
//   Ready_out      (in)      downstream accepts the beat

package mxv_pkg;
  typedef logic [7:0] uint8_t;
endpackage

module mux4a1_collector
  import mxv_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  uint8_t     Data_in_0,
  input  uint8_t     Data_in_1,
  input  uint8_t     Data_in_2,
  input  uint8_t     Data_in_3,
  input  logic       Valid_in_0,
  input  logic       Valid_in_1,
  input  logic       Valid_in_2,
  input  logic       Valid_in_3,
  output logic       Ready_in_0,
  output logic       Ready_in_1,
  output logic       Ready_in_2,
  output logic       Ready_in_3,
  output uint8_t     Data_out,
  output logic [1:0] Selector,
  output logic       Valid_out,
  input  logic       Ready_out
);

  logic [3:0] valid_vec;
  uint8_t     data_vec [4];

  logic       valid_q;
  uint8_t     data_q;
  logic [1:0] sel_q;
  logic [1:0] last_grant;

  logic       load;
  logic       any_valid;
  logic       accept;
  logic [1:0] winner;
  logic [1:0] scan_idx;

  assign valid_vec   = {Valid_in_3, Valid_in_2, Valid_in_1, Valid_in_0};
  assign data_vec[0] = Data_in_0;
  assign data_vec[1] = Data_in_1;
  assign data_vec[2] = Data_in_2;
  assign data_vec[3] = Data_in_3;

  // The output stage can take a new beat when it is empty or being drained
  // this cycle; this gives full throughput with Ready_out held high while
  // Valid_out itself stays purely registered.
  assign load = !valid_q || Ready_out;

  // Arbitration. Round-robin scans upward from the channel after the last
  // one granted, wrapping 3->0, so the 2-bit addition wraps for free.
  // Fixed priority scans downward so the lowest valid index wins last.
  always_comb begin
    winner    = 2'd0;
    any_valid = 1'b0;
    scan_idx  = 2'd0;
    if (RR_EN) begin
      for (int i = 0; i < 4; i++) begin
        scan_idx = last_grant + 2'(i + 1);
        if (!any_valid && valid_vec[scan_idx]) begin
          winner    = scan_idx;
          any_valid = 1'b1;
        end
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (valid_vec[i]) begin
          winner    = 2'(i);
          any_valid = 1'b1;
        end
      end
    end
  end

  // rst_n gates the handshake so nothing is accepted while reset is held,
  // even though the cleared output stage would otherwise report load=1.
  assign accept = rst_n && load && any_valid;

  assign Ready_in_0 = accept && (winner == 2'd0);
  assign Ready_in_1 = accept && (winner == 2'd1);
  assign Ready_in_2 = accept && (winner == 2'd2);
  assign Ready_in_3 = accept && (winner == 2'd3);

  // One-entry output register. last_grant resets to 3 so channel 0 is the
  // first round-robin candidate after reset; it only moves on an accepted
  // input transfer. Data/Selector keep their old values when the stage empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      data_q     <= 8'h00;
      sel_q      <= 2'b00;
      last_grant <= 2'b11;
    end else if (load) begin
      if (any_valid) begin
        valid_q <= 1'b1;
        data_q  <= data_vec[winner];
        sel_q   <= winner;
        if (RR_EN) begin
          last_grant <= winner;
        end
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign Data_out  = data_q;
  assign Selector  = sel_q;
  assign Valid_out = valid_q;

endmodule

// File: tb/tb_mux4a1_collector.sv
// tb_mux4a1_collector
//
// Purpose: self-checking bench for mux4a1_collector. Two instances share the
// same inputs: one round-robin (RR_EN=1) and one fixed priority (RR_EN=0).
// A behavioural model of each tracks the expected output beat and arbitration
// pointer; a compare process checks every DUT output against it on each
// falling edge. Directed scenarios add hand-computed literal expectations,
// then randomized traffic with occasional asynchronous reset pulses follows.

module tb_mux4a1_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ready_out = 1'b0;
  logic [3:0] vin = 4'b0000;
  logic [7:0] din [4];

  logic [3:0] rr_rdy, fp_rdy;
  logic [7:0] rr_dout, fp_dout;
  logic [1:0] rr_sel, fp_sel;
  logic       rr_vout, fp_vout;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Model state, index 0 = round-robin instance, 1 = fixed priority instance
  logic [7:0] m_data  [2] = '{8'h00, 8'h00};
  logic [1:0] m_sel   [2] = '{2'd0, 2'd0};
  logic       m_valid [2] = '{1'b0, 1'b0};
  logic [1:0] m_lg    [2] = '{2'd3, 2'd3};

  always #5 clk = ~clk;

  mux4a1_collector #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .Data_in_0(din[0]), .Data_in_1(din[1]), .Data_in_2(din[2]), .Data_in_3(din[3]),
    .Valid_in_0(vin[0]), .Valid_in_1(vin[1]), .Valid_in_2(vin[2]), .Valid_in_3(vin[3]),
    .Ready_in_0(rr_rdy[0]), .Ready_in_1(rr_rdy[1]), .Ready_in_2(rr_rdy[2]), .Ready_in_3(rr_rdy[3]),
    .Data_out(rr_dout), .Selector(rr_sel), .Valid_out(rr_vout), .Ready_out(ready_out)
  );

  mux4a1_collector #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .Data_in_0(din[0]), .Data_in_1(din[1]), .Data_in_2(din[2]), .Data_in_3(din[3]),
    .Valid_in_0(vin[0]), .Valid_in_1(vin[1]), .Valid_in_2(vin[2]), .Valid_in_3(vin[3]),
    .Ready_in_0(fp_rdy[0]), .Ready_in_1(fp_rdy[1]), .Ready_in_2(fp_rdy[2]), .Ready_in_3(fp_rdy[3]),
    .Data_out(fp_dout), .Selector(fp_sel), .Valid_out(fp_vout), .Ready_out(ready_out)
  );

  // Arbitration rule: mode 0 takes the first valid channel after the last
  // grant (mod 4), mode 1 takes the lowest valid index; -1 means none valid.
  function automatic int pick(input int mode, input logic [3:0] v, input logic [1:0] lg);
    if (mode == 0) begin
      for (int k = 1; k <= 4; k++) begin
        int idx;
        idx = (int'(lg) + k) % 4;
        if (v[idx]) return idx;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (v[i]) return i;
      end
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input int m);
    int w;
    if (!rst_n) return 4'b0000;
    w = pick(m, vin, m_lg[m]);
    if ((!m_valid[m] || ready_out) && w >= 0) return 4'b0001 << w;
    return 4'b0000;
  endfunction

  // Model of the output stage: a beat moves in whenever the stage is empty
  // or draining and some channel is valid; otherwise a drained stage empties.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_valid[m] <= 1'b0;
        m_data[m]  <= 8'h00;
        m_sel[m]   <= 2'd0;
        m_lg[m]    <= 2'd3;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        automatic int w = pick(m, vin, m_lg[m]);
        if (!m_valid[m] || ready_out) begin
          if (w >= 0) begin
            m_valid[m] <= 1'b1;
            m_data[m]  <= din[w];
            m_sel[m]   <= 2'(w);
            m_lg[m]    <= 2'(w);
          end else begin
            m_valid[m] <= 1'b0;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and hold for a full cycle
  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d, input logic rdy);
    @(posedge clk);
    #1;
    vin = v;
    for (int n = 0; n < 4; n++) din[n] = d[8*n +: 8];
    ready_out = rdy;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    vin = 4'b0000;
    ready_out = 1'b0;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  // Per-cycle scoreboard on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("rr ready_in", {28'd0, rr_rdy}, {28'd0, exp_ready(0)});
      checkOutput("rr valid_out", {31'd0, rr_vout}, {31'd0, m_valid[0]});
      checkOutput("rr data_out", {24'd0, rr_dout}, {24'd0, m_data[0]});
      checkOutput("rr selector", {30'd0, rr_sel}, {30'd0, m_sel[0]});
      checkOutput("fp ready_in", {28'd0, fp_rdy}, {28'd0, exp_ready(1)});
      checkOutput("fp valid_out", {31'd0, fp_vout}, {31'd0, m_valid[1]});
      checkOutput("fp data_out", {24'd0, fp_dout}, {24'd0, m_data[1]});
      checkOutput("fp selector", {30'd0, fp_sel}, {30'd0, m_sel[1]});
    end
  end

  initial begin
    for (int n = 0; n < 4; n++) din[n] = 8'h00;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;

    // Reset values and no handshake while reset is held
    checkOutput("reset valid_out", {31'd0, rr_vout}, 32'd0);
    checkOutput("reset data_out", {24'd0, rr_dout}, 32'h00);
    checkOutput("reset selector", {30'd0, rr_sel}, 32'd0);
    vin = 4'hF;
    ready_out = 1'b1;
    #1;
    checkOutput("reset rr ready_in", {28'd0, rr_rdy}, 32'd0);
    checkOutput("reset fp ready_in", {28'd0, fp_rdy}, 32'd0);
    vin = 4'h0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Single beat from channel 2
    applyStimulus(4'b0100, 32'h00A5_0000, 1'b1);
    #1;
    checkOutput("single ready_in", {28'd0, rr_rdy}, 32'b0100);
    applyStimulus(4'b0000, 32'h0, 1'b1);
    #1;
    checkOutput("single valid_out", {31'd0, rr_vout}, 32'd1);
    checkOutput("single data_out", {24'd0, rr_dout}, 32'hA5);
    checkOutput("single selector", {30'd0, rr_sel}, 32'd2);

    // Round-robin rotation with all four channels valid
    doReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(4'hF, 32'h1312_1110, 1'b1);
      #1;
      checkOutput("rr rotate ready_in", {28'd0, rr_rdy}, 32'd1 << (i % 4));
      checkOutput("fp all-valid ready_in", {28'd0, fp_rdy}, 32'd1);
      if (i > 0) begin
        checkOutput("rr rotate valid_out", {31'd0, rr_vout}, 32'd1);
        checkOutput("rr rotate selector", {30'd0, rr_sel}, 32'((i - 1) % 4));
        checkOutput("rr rotate data_out", {24'd0, rr_dout}, 32'h10 + 32'((i - 1) % 4));
      end
    end

    // Fixed priority: channel 1 always beats channel 3
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b1010, 32'h3300_1100, 1'b1);
      #1;
      checkOutput("fp prio ready_in", {28'd0, fp_rdy}, 32'b0010);
      if (i > 0) begin
        checkOutput("fp prio selector", {30'd0, fp_sel}, 32'd1);
        checkOutput("fp prio data_out", {24'd0, fp_dout}, 32'h11);
      end
    end

    // Backpressure holds the beat and blocks new transfers
    doReset();
    applyStimulus(4'b0001, 32'h0000_003C, 1'b0);
    #1;
    checkOutput("bp first ready_in", {28'd0, rr_rdy}, 32'b0001);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0001, 32'h0000_0077, 1'b0);
      #1;
      checkOutput("bp hold valid_out", {31'd0, rr_vout}, 32'd1);
      checkOutput("bp hold data_out", {24'd0, rr_dout}, 32'h3C);
      checkOutput("bp hold selector", {30'd0, rr_sel}, 32'd0);
      checkOutput("bp hold ready_in", {28'd0, rr_rdy}, 32'd0);
    end
    applyStimulus(4'b0001, 32'h0000_0077, 1'b1);
    #1;
    checkOutput("bp release ready_in", {28'd0, rr_rdy}, 32'b0001);
    checkOutput("bp release data_out", {24'd0, rr_dout}, 32'h3C);
    applyStimulus(4'b0000, 32'h0, 1'b1);
    #1;
    checkOutput("bp next data_out", {24'd0, rr_dout}, 32'h77);
    checkOutput("bp next valid_out", {31'd0, rr_vout}, 32'd1);

    // Wrap from channel 3 back to channel 0
    doReset();
    applyStimulus(4'b1001, 32'hD300_00D0, 1'b1);
    #1;
    checkOutput("wrap first ready_in", {28'd0, rr_rdy}, 32'b0001);
    applyStimulus(4'b1001, 32'hD300_00D0, 1'b1);
    #1;
    checkOutput("wrap second ready_in", {28'd0, rr_rdy}, 32'b1000);
    checkOutput("wrap second selector", {30'd0, rr_sel}, 32'd0);
    applyStimulus(4'b1001, 32'hD300_00D0, 1'b1);
    #1;
    checkOutput("wrap third ready_in", {28'd0, rr_rdy}, 32'b0001);
    checkOutput("wrap third selector", {30'd0, rr_sel}, 32'd3);
    checkOutput("wrap third data_out", {24'd0, rr_dout}, 32'hD3);

    // Asynchronous reset while a beat is held
    doReset();
    applyStimulus(4'b0010, 32'h0000_5A00, 1'b0);
    applyStimulus(4'b0010, 32'h0000_5A00, 1'b0);
    #1;
    checkOutput("midreset held valid_out", {31'd0, rr_vout}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset valid_out", {31'd0, rr_vout}, 32'd0);
    checkOutput("midreset data_out", {24'd0, rr_dout}, 32'h00);
    checkOutput("midreset selector", {30'd0, rr_sel}, 32'd0);
    checkOutput("midreset rr ready_in", {28'd0, rr_rdy}, 32'd0);
    checkOutput("midreset fp ready_in", {28'd0, fp_rdy}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midreset held ready_in", {28'd0, rr_rdy}, 32'd0);
    #2 rst_n = 1'b1;

    // Randomized traffic with occasional asynchronous reset pulses
    for (int c = 0; c < 3000; c++) begin
      applyStimulus(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
      if (c % 700 == 699) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
